// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// All outputs except tx_ready come straight from flops.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shifted;
    logic              parity;
    logic              bit_end;

    assign bit_end  = (cnt == CNT_LAST);
    assign shifted  = shreg >> 1;
    // Gated by reset so the block never advertises readiness while held in reset.
    assign tx_ready = reset && (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            parity <= 1'b0;
            tx_out <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE)
                cnt <= bit_end ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        state  <= START;
                        shreg  <= tx_data;
                        parity <= ^tx_data;
                        tx_out <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state  <= DATA;
                        tx_out <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx == IDX_LAST) begin
                            idx <= '0;
                            if (PARITY_EN != 0) begin
                                state  <= PARITY;
                                tx_out <= parity;
                            end else begin
                                state  <= STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            idx    <= idx + 1'b1;
                            shreg  <= shifted;
                            tx_out <= shifted[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: three instances cover the default build, no-parity,
// and the one-cycle-per-bit / one-bit-word corner.
module tb_serial_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] a_data, b_data;
    logic [0:0] c_data;
    logic a_valid, a_ready, a_out, a_busy, a_done;
    logic b_valid, b_ready, b_out, b_busy, b_done;
    logic c_valid, c_ready, c_out, c_busy, c_done;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
        .clk(clk), .reset(rst), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .tx_out(a_out), .busy(a_busy), .done(a_done));

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_b (
        .clk(clk), .reset(rst), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .tx_out(b_out), .busy(b_busy), .done(b_done));

    serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut_c (
        .clk(clk), .reset(rst), .tx_data(c_data), .tx_valid(c_valid),
        .tx_ready(c_ready), .tx_out(c_out), .busy(c_busy), .done(c_done));

    int   n_checks = 0;
    int   n_fail   = 0;
    logic obs_out [0:127];
    int   busy_cnt, done_cnt, done_pos;
    logic ready_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives at the current time (caller is at a negedge), waits one acceptance edge.
    task automatic send(input int sel, input logic [7:0] d, input bit hold);
        case (sel)
            0:       begin a_data = d;    a_valid = 1'b1; end
            1:       begin b_data = d;    b_valid = 1'b1; end
            default: begin c_data = d[0]; c_valid = 1'b1; end
        endcase
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        end
    endtask

    // mode 1: back-to-back 0x00/0xFF; mode 2: disturb inputs mid-frame.
    task automatic collect(input int sel, input int win, input int mode);
        logic o, b, d, r;
        busy_cnt = 0; done_cnt = 0; done_pos = -1; ready_done = 1'b0;
        for (int k = 0; k < win; k++) begin
            case (sel)
                0:       begin o = a_out; b = a_busy; d = a_done; r = a_ready; end
                1:       begin o = b_out; b = b_busy; d = b_done; r = b_ready; end
                default: begin o = c_out; b = c_busy; d = c_done; r = c_ready; end
            endcase
            obs_out[k] = o;
            if (b) busy_cnt++;
            if (d) begin
                done_cnt++;
                if (done_pos < 0) begin done_pos = k; ready_done = r; end
            end
            if (mode == 1) begin
                if (k == 0)  a_data  = 8'hFF;
                if (k == 45) a_valid = 1'b0;
            end
            if (mode == 2) begin
                if (k == 5)  begin a_data = 8'h3C; a_valid = 1'b1; end
                if (k == 9)  a_valid = 1'b0;
                if (k == 20) a_valid = 1'b1;
                if (k == 40) a_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input int start, input int cpb,
                               input int nbits, input logic [15:0] bits);
        for (int i = 0; i < nbits; i++)
            for (int j = 0; j < cpb; j++)
                check($sformatf("%s_bit%0d_c%0d", tag, i, j), obs_out[start + i*cpb + j], bits[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_data = '0; b_data = '0; c_data = '0;

        @(negedge clk);
        check("rst_tx_out", a_out, 1);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_ready", a_ready, 0);
        check("rst_c_tx_out", c_out, 1);

        // Release and offer a word before the first rising edge.
        rst = 1'b1;
        #1;
        check("ready_after_rst", a_ready, 1);
        send(0, 8'hA5, 0);
        collect(0, 48, 0);
        check_frame("a5", 0, 4, 11, 16'b1_0_10100101_0);
        check("a5_busy_cycles", busy_cnt, 44);
        check("a5_done_count", done_cnt, 1);
        check("a5_done_pos", done_pos, 44);
        check("a5_ready_at_done", ready_done, 1);

        send(0, 8'h01, 0);
        collect(0, 48, 0);
        check_frame("a01", 0, 4, 11, 16'b1_1_00000001_0);
        check("a01_busy_cycles", busy_cnt, 44);
        check("a01_done_pos", done_pos, 44);

        send(1, 8'h01, 0);
        collect(1, 44, 0);
        check_frame("nopar01", 0, 4, 10, 16'b1_00000001_0);
        check("nopar_busy_cycles", busy_cnt, 40);
        check("nopar_done_count", done_cnt, 1);
        check("nopar_done_pos", done_pos, 40);

        send(0, 8'h00, 1);
        collect(0, 92, 1);
        check_frame("b2b_first", 0, 4, 11, 16'b1_0_00000000_0);
        check("b2b_gap_idle", obs_out[44], 1);
        check_frame("b2b_second", 45, 4, 11, 16'b1_0_11111111_0);
        check("b2b_busy_cycles", busy_cnt, 88);
        check("b2b_done_count", done_cnt, 2);
        check("b2b_first_done_pos", done_pos, 44);

        send(0, 8'hA5, 0);
        collect(0, 48, 2);
        check_frame("disturb", 0, 4, 11, 16'b1_0_10100101_0);
        check("disturb_busy_cycles", busy_cnt, 44);
        check("disturb_done_count", done_cnt, 1);

        send(0, 8'hA5, 0);
        repeat (19) @(negedge clk);
        check("pre_abort_tx_out", a_out, 0);
        rst = 1'b0;
        #1;
        check("abort_tx_out", a_out, 1);
        check("abort_busy", a_busy, 0);
        check("abort_ready", a_ready, 0);
        @(negedge clk);
        check("abort_done", a_done, 0);
        rst = 1'b1;
        send(0, 8'h5A, 0);
        collect(0, 48, 0);
        check_frame("after_abort_5a", 0, 4, 11, 16'b1_0_01011010_0);
        check("after_abort_busy", busy_cnt, 44);
        check("after_abort_done_count", done_cnt, 1);
        check("after_abort_done_pos", done_pos, 44);

        send(2, 8'h01, 0);
        collect(2, 6, 0);
        check_frame("min_cfg", 0, 1, 4, 16'b1110);
        check("min_cfg_busy", busy_cnt, 4);
        check("min_cfg_done_pos", done_pos, 4);
        check("min_cfg_done_count", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
